chess_input_ctrl: RTL and testbench

Button-conditioning and turn-control stage directly upstream of the chess-clock top (`Top`). It synchronises and debounces the three raw push-buttons: player-0 clock button, player-1 clock button and pause. A turn FSM then drives `Top`'s `CE`, `SELECT` and `STOP` inputs. It consumes `Top`'s two overflow flags so that play freezes when a flag falls.

---
 rtl/chess_pkg.sv | 19 +
 rtl/chess_input_ctrl_if.sv | 26 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/chess_input_ctrl.sv | 115 +++++++++++
 tb/tb_chess_input_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared types and constants for the chess-clock input stage.
package chess_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN_P0 = 3'd1,
      ST_RUN_P1 = 3'd2,
      ST_PAUSED = 3'd3,
      ST_FLAG   = 3'd4
   } state_t;

   localparam logic [1:0] LOSER_NONE = 2'b00;
   localparam logic [1:0] LOSER_P0   = 2'b01;
   localparam logic [1:0] LOSER_P1   = 2'b10;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_CNT_W           = 20;

endpackage

// File: rtl/chess_input_ctrl_if.sv
// Button/overflow inputs and Top-facing control outputs of the input stage.
interface chess_input_ctrl_if;

   logic       BTN_P0;
   logic       BTN_P1;
   logic       BTN_PAUSE;
   logic       OVERFLOW1;
   logic       OVERFLOW2;
   logic       CE;
   logic       SELECT;
   logic       STOP;
   logic       TURN_PULSE;
   logic [1:0] LOSER;

   // master: the controller; slave: the board/Top side feeding it
   modport master (
      input  BTN_P0, BTN_P1, BTN_PAUSE, OVERFLOW1, OVERFLOW2,
      output CE, SELECT, STOP, TURN_PULSE, LOSER
   );

   modport slave (
      output BTN_P0, BTN_P1, BTN_PAUSE, OVERFLOW1, OVERFLOW2,
      input  CE, SELECT, STOP, TURN_PULSE, LOSER
   );

endinterface

// File: rtl/btn_debounce.sv
// 2-FF synchroniser, stable-count debouncer and registered rising-edge strobe.
module btn_debounce
   import chess_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic CLK,
   input  logic CLR_N,
   input  logic BTN,
   output logic PRESS
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;

   // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_sync    <= '0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], BTN};
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   assign PRESS = r_press;

endmodule

// File: rtl/chess_input_ctrl.sv
// Debounced buttons drive a turn FSM producing CE/SELECT/STOP for the chess clock.
module chess_input_ctrl
   import chess_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic              CLK,
   input  logic              CLR_N,
   chess_input_ctrl_if.master bus
);

   logic w_press_p0, w_press_p1, w_press_pause;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_p0 (
      .CLK(CLK), .CLR_N(CLR_N), .BTN(bus.BTN_P0), .PRESS(w_press_p0)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_p1 (
      .CLK(CLK), .CLR_N(CLR_N), .BTN(bus.BTN_P1), .PRESS(w_press_p1)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
      .CLK(CLK), .CLR_N(CLR_N), .BTN(bus.BTN_PAUSE), .PRESS(w_press_pause)
   );

   state_t     r_state, w_nxt_state;
   logic       r_saved, w_nxt_saved;
   logic       r_ce, w_nxt_ce;
   logic       r_sel, w_nxt_sel;
   logic       r_stop, w_nxt_stop;
   logic       r_pulse, w_nxt_pulse;
   logic [1:0] r_loser, w_nxt_loser;

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_state <= ST_IDLE;
         r_saved <= 1'b0;
         r_ce    <= 1'b0;
         r_sel   <= 1'b0;
         r_stop  <= 1'b1;
         r_pulse <= 1'b0;
         r_loser <= LOSER_NONE;
      end else begin
         r_state <= w_nxt_state;
         r_saved <= w_nxt_saved;
         r_ce    <= w_nxt_ce;
         r_sel   <= w_nxt_sel;
         r_stop  <= w_nxt_stop;
         r_pulse <= w_nxt_pulse;
         r_loser <= w_nxt_loser;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_saved = r_saved;
      w_nxt_pulse = 1'b0;
      w_nxt_loser = r_loser;

      case (r_state)
         ST_IDLE: begin
            // The player who presses hands the first move to the opponent.
            if (w_press_p1 && !w_press_p0)      w_nxt_state = ST_RUN_P0;
            else if (w_press_p0 && !w_press_p1) w_nxt_state = ST_RUN_P1;
         end
         ST_RUN_P0: begin
            if (w_press_pause) begin
               w_nxt_state = ST_PAUSED;
               w_nxt_saved = 1'b0;
            end else if (w_press_p0) begin
               w_nxt_state = ST_RUN_P1;
               w_nxt_pulse = 1'b1;
            end
         end
         ST_RUN_P1: begin
            if (w_press_pause) begin
               w_nxt_state = ST_PAUSED;
               w_nxt_saved = 1'b1;
            end else if (w_press_p1) begin
               w_nxt_state = ST_RUN_P0;
               w_nxt_pulse = 1'b1;
            end
         end
         ST_PAUSED: begin
            if (w_press_pause) w_nxt_state = r_saved ? ST_RUN_P1 : ST_RUN_P0;
         end
         default: ;
      endcase

      // A falling flag overrides any press seen in the same cycle.
      if (r_state != ST_FLAG && (bus.OVERFLOW1 || bus.OVERFLOW2)) begin
         w_nxt_state = ST_FLAG;
         w_nxt_pulse = 1'b0;
         if (bus.OVERFLOW1 && bus.OVERFLOW2) w_nxt_loser = r_sel ? LOSER_P1 : LOSER_P0;
         else if (bus.OVERFLOW1)             w_nxt_loser = LOSER_P0;
         else                                w_nxt_loser = LOSER_P1;
      end

      w_nxt_ce   = (w_nxt_state == ST_RUN_P0) || (w_nxt_state == ST_RUN_P1);
      w_nxt_stop = ~w_nxt_ce;

      case (w_nxt_state)
         ST_RUN_P0: w_nxt_sel = 1'b0;
         ST_RUN_P1: w_nxt_sel = 1'b1;
         ST_PAUSED: w_nxt_sel = w_nxt_saved;
         default:   w_nxt_sel = r_sel;
      endcase
   end

   assign bus.CE         = r_ce;
   assign bus.SELECT     = r_sel;
   assign bus.STOP       = r_stop;
   assign bus.TURN_PULSE = r_pulse;
   assign bus.LOSER      = r_loser;

endmodule

// File: tb/tb_chess_input_ctrl.sv
// Directed vector bench for chess_input_ctrl with a short debounce window.
module tb_chess_input_ctrl;

   localparam int DB = 4;

   // expected output packing: {CE, SELECT, STOP, TURN_PULSE, LOSER[1:0]}
   localparam logic [5:0] IDLE0 = 6'b001000;
   localparam logic [5:0] RP0   = 6'b100000;
   localparam logic [5:0] RP0T  = 6'b100100;
   localparam logic [5:0] RP1   = 6'b110000;
   localparam logic [5:0] RP1T  = 6'b110100;
   localparam logic [5:0] PS1   = 6'b011000;
   localparam logic [5:0] FL0   = 6'b001001;
   localparam logic [5:0] FL1   = 6'b011010;

   // input packing: {BTN_P0, BTN_P1, BTN_PAUSE, OVERFLOW1, OVERFLOW2}
   typedef struct {
      logic [4:0] in;
      int         cyc;
      logic [5:0] exp;
   } vec_t;

   localparam int NV = 36;
   vec_t vt [NV];

   logic clk = 1'b0;
   logic clr_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   chess_input_ctrl_if bus ();

   chess_input_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
      .CLK(clk), .CLR_N(clr_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [4:0] v);
      {bus.BTN_P0, bus.BTN_P1, bus.BTN_PAUSE, bus.OVERFLOW1, bus.OVERFLOW2} = v;
   endtask

   task automatic check(input string nm, input logic [5:0] exp);
      logic [5:0] act;
      act = {bus.CE, bus.SELECT, bus.STOP, bus.TURN_PULSE, bus.LOSER};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: ce/sel/stop/pulse/loser got %b want %b", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      drive(5'b0);
      clr_n = 1'b0;
      tick(2);
      @(negedge clk);
      clr_n = 1'b1;
      tick(1);
   endtask

   initial begin
      vt[0]  = '{5'b01000, 7,  IDLE0};
      vt[1]  = '{5'b01000, 1,  RP0};
      vt[2]  = '{5'b01000, 2,  RP0};
      vt[3]  = '{5'b00000, 8,  RP0};
      vt[4]  = '{5'b10000, 7,  RP0};
      vt[5]  = '{5'b10000, 1,  RP1T};
      vt[6]  = '{5'b10000, 1,  RP1};
      vt[7]  = '{5'b00000, 8,  RP1};
      vt[8]  = '{5'b10000, 10, RP1};
      vt[9]  = '{5'b00000, 8,  RP1};
      vt[10] = '{5'b01000, 1,  RP1};
      vt[11] = '{5'b00000, 3,  RP1};
      vt[12] = '{5'b01000, 2,  RP1};
      vt[13] = '{5'b00000, 3,  RP1};
      vt[14] = '{5'b01000, 3,  RP1};
      vt[15] = '{5'b00000, 8,  RP1};
      vt[16] = '{5'b01000, 6,  RP1};
      vt[17] = '{5'b00000, 2,  RP0T};
      vt[18] = '{5'b00000, 8,  RP0};
      vt[19] = '{5'b10000, 8,  RP1T};
      vt[20] = '{5'b00000, 8,  RP1};
      vt[21] = '{5'b00100, 8,  PS1};
      vt[22] = '{5'b00000, 8,  PS1};
      vt[23] = '{5'b10000, 8,  PS1};
      vt[24] = '{5'b00000, 8,  PS1};
      vt[25] = '{5'b00100, 8,  RP1};
      vt[26] = '{5'b00000, 8,  RP1};
      vt[27] = '{5'b01000, 8,  RP0T};
      vt[28] = '{5'b00000, 8,  RP0};
      vt[29] = '{5'b10000, 7,  RP0};
      vt[30] = '{5'b10010, 1,  FL0};
      vt[31] = '{5'b00000, 8,  FL0};
      vt[32] = '{5'b01000, 10, FL0};
      vt[33] = '{5'b00000, 8,  FL0};
      vt[34] = '{5'b00100, 10, FL0};
      vt[35] = '{5'b00000, 8,  FL0};

      do_reset();
      check("reset_state", IDLE0);

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].in);
         tick(vt[i].cyc);
         check($sformatf("vec%0d", i), vt[i].exp);
      end

      // simultaneous player presses in IDLE, then pause in IDLE
      do_reset();
      drive(5'b11000);
      tick(10);
      check("idle_both_press", IDLE0);
      drive(5'b0);
      tick(8);
      drive(5'b00100);
      tick(10);
      check("idle_pause", IDLE0);
      drive(5'b0);
      tick(8);

      // both flags together while player 1 runs -> blame the running side
      do_reset();
      drive(5'b10000);
      tick(8);
      check("idle_p0_to_run_p1", RP1);
      drive(5'b0);
      tick(8);
      drive(5'b00011);
      tick(1);
      check("both_ovf_sel1", FL1);
      drive(5'b0);
      tick(3);
      check("flag_hold", FL1);

      // asynchronous clear between edges in RUN_P1
      do_reset();
      drive(5'b10000);
      tick(8);
      drive(5'b0);
      tick(8);
      check("pre_async_run_p1", RP1);
      #3;
      clr_n = 1'b0;
      #1;
      check("async_clear", IDLE0);
      tick(1);
      do_reset();
      check("after_async_reset", IDLE0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
